mag_compare_display: RTL and testbench

Parametrised W-bit magnitude comparator with debounced mode buttons, a latched mode state machine and a multiplexed 4-digit seven-segment driver. Operands `a` and `b` come from board switches; `disp` drives the shared segment bus and the anodes; `ledsbt` mirrors the operands on LEDs. It supersedes the fixed 4-bit, level-sensitive-button comparator, adding:
- generic width and signed compare;
- registered outputs;
- button debouncing;
- latched, toggleable modes.

---
 rtl/mag_compare_display_if.sv | 35 +++
 rtl/mag_compare_display.sv | 180 ++++++++++++++++++
 tb/tb_mag_compare_display.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mag_compare_display_if.sv
// mag_compare_display_if
// Purpose : bundles the board-side signals of the magnitude comparator
//           display block.
// Signals : a, b    - W-bit operands (switches)
//           sgn     - 1 = two's-complement compare, 0 = unsigned
//           b1..b3  - raw mode buttons (EQ / LT / GT)
//           disp    - {seg[7:0], an[3:0]}, both active-low
//           ledsbt  - registered {a, b}
//           flags   - registered {lt, eq, gt}
//           mode    - 0 IDLE, 1 EQ, 2 LT, 3 GT
// Modports: master drives operands/buttons, slave is the comparator.
interface mag_compare_display_if #(
  parameter int W = 8
);
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           b1;
  logic           b2;
  logic           b3;
  logic [11:0]    disp;
  logic [2*W-1:0] ledsbt;
  logic [2:0]     flags;
  logic [1:0]     mode;

  modport master (
    output a, b, sgn, b1, b2, b3,
    input  disp, ledsbt, flags, mode
  );

  modport slave (
    input  a, b, sgn, b1, b2, b3,
    output disp, ledsbt, flags, mode
  );
endinterface

// File: rtl/mag_compare_display.sv
// mag_compare_display
// Purpose : W-bit signed/unsigned magnitude comparator with debounced,
//           toggling mode buttons and a multiplexed 4-digit 7-segment
//           driver showing the selected mode and its result bit.
// Ports   : clk   - system clock
//           reset - asynchronous, active-low reset
//           bus   - mag_compare_display_if.slave (operands, buttons,
//                   disp, ledsbt, flags, mode)
module mag_compare_display #(
  parameter int W            = 8,
  parameter int REFRESH_BITS = 19,
  parameter int DEB_BITS     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  mag_compare_display_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EQ   = 2'd1,
    LT   = 2'd2,
    GT   = 2'd3
  } mode_e;

  localparam logic [DEB_BITS-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------
  // Comparator and LED mirror
  // ---------------------------------------------------------------
  logic           lt_c, eq_c, gt_c;
  logic [2:0]     flags_q;
  logic [2*W-1:0] ledsbt_q;

  always_comb begin
    eq_c = (bus.a == bus.b);
    lt_c = bus.sgn ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
    gt_c = !lt_c && !eq_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q  <= 3'b000;
      ledsbt_q <= '0;
    end else begin
      flags_q  <= {lt_c, eq_c, gt_c};
      ledsbt_q <= {bus.a, bus.b};
    end
  end

  // ---------------------------------------------------------------
  // Button debouncers: index 0 = b1, 1 = b2, 2 = b3
  // ---------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {bus.b3, bus.b2, bus.b1};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_deb
      logic                s1_q, s2_q;
      logic                stable_q, stable_prev_q;
      logic [DEB_BITS-1:0] cnt_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_q          <= 1'b0;
          s2_q          <= 1'b0;
          stable_q      <= 1'b0;
          stable_prev_q <= 1'b0;
          cnt_q         <= '0;
        end else begin
          s1_q          <= btn_raw[gi];
          s2_q          <= s1_q;
          stable_prev_q <= stable_q;
          // Any return to the stable level restarts the interval, so a
          // glitch must persist for the full count to be accepted.
          if (s2_q == stable_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_MAX) begin
            stable_q <= s2_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      // Rising edge of the stable level only; releases are ignored.
      assign press[gi] = stable_q & ~stable_prev_q;
    end
  endgenerate

  // ---------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------
  mode_e mode_q, mode_d;
  mode_e target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= IDLE;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    target = IDLE;
    case (press)
      3'b001:  target = EQ;
      3'b010:  target = LT;
      3'b100:  target = GT;
      default: target = IDLE;
    endcase
    // Only a lone press acts; simultaneous presses leave the mode alone.
    if (press == 3'b001 || press == 3'b010 || press == 3'b100) begin
      mode_d = (mode_q == target) ? IDLE : target;
    end
  end

  // ---------------------------------------------------------------
  // Display multiplexer
  // ---------------------------------------------------------------
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              sel;
  logic                    result;
  logic [7:0]              seg_d;
  logic [3:0]              an_d;
  logic [11:0]             disp_q;

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    case (mode_q)
      EQ:      result = flags_q[1];
      LT:      result = flags_q[2];
      GT:      result = flags_q[0];
      default: result = 1'b0;
    endcase
  end

  always_comb begin
    seg_d = 8'hFF;
    an_d  = 4'hF;
    if (mode_q != IDLE) begin
      case (sel)
        2'd0: begin
          an_d = 4'b0111;
          case (mode_q)
            EQ:      seg_d = 8'b11101101;
            LT:      seg_d = 8'b11100011;
            default: seg_d = 8'b01000011;
          endcase
        end
        2'd1: an_d = 4'b1011;
        2'd2: an_d = 4'b1101;
        default: begin
          an_d  = 4'b1110;
          seg_d = result ? 8'b10011111 : 8'b00000011;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      disp_q    <= 12'hFFF;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      disp_q    <= {seg_d, an_d};
    end
  end

  assign bus.disp   = disp_q;
  assign bus.ledsbt = ledsbt_q;
  assign bus.flags  = flags_q;
  assign bus.mode   = mode_q;

endmodule

// File: tb/tb_mag_compare_display.sv
module tb_mag_compare_display;

  localparam int W = 4;
  localparam logic [1:0] F_DISP = 2'd0, F_LED = 2'd1, F_FLAGS = 2'd2, F_MODE = 2'd3;

  typedef struct packed {
    logic [1:0]  fld;
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   rel = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mag_compare_display_if #(.W(W)) bus ();

  mag_compare_display #(
    .W(W), .REFRESH_BITS(4), .DEB_BITS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic string fname(input logic [1:0] f);
    case (f)
      F_DISP:  return "disp";
      F_LED:   return "ledsbt";
      F_FLAGS: return "flags";
      default: return "mode";
    endcase
  endfunction

  function automatic logic [15:0] actual(input logic [1:0] f);
    case (f)
      F_DISP:  return 16'(bus.disp);
      F_LED:   return 16'(bus.ledsbt);
      F_FLAGS: return 16'(bus.flags);
      default: return 16'(bus.mode);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [15:0] act;
        act = actual(sb[i].fld);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%h required=%h",
                   fname(sb[i].fld), cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input logic [1:0] f, input logic [15:0] v, input int at);
    exp_t e;
    e.fld = f;
    e.val = v;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int sel_at(input int c);
    return ((c - rel - 1) >> 2) & 3;
  endfunction

  function automatic int next_sel(input int from, input int s);
    for (int c = from; c < from + 16; c++)
      if (sel_at(c) == s) return c;
    return from;
  endfunction

  task automatic set_btn(input int btn, input logic v);
    case (btn)
      1:       bus.b1 = v;
      2:       bus.b2 = v;
      default: bus.b3 = v;
    endcase
  endtask

  task automatic press(input int btn, input logic [1:0] from_m, input logic [1:0] to_m);
    int c;
    c = cyc;
    set_btn(btn, 1'b1);
    push(F_MODE, 16'(from_m), c + 6);
    push(F_MODE, 16'(to_m), c + 7);
    tick(10);
    set_btn(btn, 1'b0);
    push(F_MODE, 16'(to_m), cyc + 8);
    tick(9);
  endtask

  task automatic push_reset_state(input int at);
    push(F_DISP, 16'hFFF, at);
    push(F_LED, 16'h00, at);
    push(F_FLAGS, 16'h0, at);
    push(F_MODE, 16'h0, at);
  endtask

  initial begin
    int c, s, guard;

    reset  = 1'b0;
    bus.a  = 4'($urandom);
    bus.b  = 4'($urandom);
    bus.sgn = 1'($urandom);
    bus.b1 = 1'($urandom);
    bus.b2 = 1'($urandom);
    bus.b3 = 1'($urandom);
    tick(3);
    checks++;
    if (bus.disp !== 12'hFFF) begin
        errors++;
        $display("FAIL disp in reset actual=%h required=fff", bus.disp);
    end
    checks++;
    if (bus.ledsbt !== 8'h00) begin
        errors++;
        $display("FAIL ledsbt in reset actual=%h required=00", bus.ledsbt);
    end
    checks++;
    if (bus.flags !== 3'b000) begin
        errors++;
        $display("FAIL flags in reset actual=%b required=000", bus.flags);
    end
    checks++;
    if (bus.mode !== 2'd0) begin
        errors++;
        $display("FAIL mode in reset actual=%0d required=0", bus.mode);
    end
    push_reset_state(cyc);
    tick(1);
    bus.a = 4'd5; bus.b = 4'd5; bus.sgn = 1'b0;
    bus.b1 = 1'b0; bus.b2 = 1'b0; bus.b3 = 1'b0;
    tick(2);
    reset = 1'b1;
    rel = cyc;
    push(F_FLAGS, 16'b010, cyc + 1);
    push(F_LED, 16'h55, cyc + 1);
    push(F_DISP, 16'hFFF, cyc + 1);
    push(F_DISP, 16'hFFF, cyc + 5);
    tick(6);

    press(1, 2'd0, 2'd1);
    s = next_sel(cyc + 2, 0);
    push(F_DISP, 16'hED7, s);
    push(F_DISP, 16'hFFB, s + 4);
    push(F_DISP, 16'hFFD, s + 8);
    push(F_DISP, 16'h9FE, s + 12);
    tick(s + 13 - cyc);

    guard = 0;
    while (!(sel_at(cyc + 1) == 3 && sel_at(cyc + 2) == 3) && guard < 32) begin
      tick(1);
      guard++;
    end
    bus.a = 4'd6;
    push(F_FLAGS, 16'b001, cyc + 1);
    push(F_LED, 16'h65, cyc + 1);
    push(F_DISP, 16'h9FE, cyc + 1);
    push(F_DISP, 16'h03E, cyc + 2);
    tick(4);

    bus.a = 4'hF; bus.b = 4'h1; bus.sgn = 1'b0;
    push(F_FLAGS, 16'b001, cyc + 1);
    push(F_LED, 16'hF1, cyc + 1);
    tick(2);
    bus.sgn = 1'b1;
    push(F_FLAGS, 16'b100, cyc + 1);
    tick(2);
    press(2, 2'd1, 2'd2);
    s = next_sel(cyc + 2, 3);
    push(F_DISP, 16'h9FE, s);
    c = next_sel(cyc + 2, 0);
    push(F_DISP, 16'hE37, c);
    tick(((s > c) ? s : c) + 1 - cyc);
    press(2, 2'd2, 2'd0);
    push(F_DISP, 16'hFFF, cyc + 2);

    c = cyc;
    for (int k = 1; k <= 50; k++) push(F_MODE, 16'h0, c + k);
    for (int k = 0; k < 10; k++) begin
      bus.b2 = 1'b1;
      tick(2);
      bus.b2 = 1'b0;
      tick(2);
    end
    tick(12);
    press(2, 2'd0, 2'd2);
    press(2, 2'd2, 2'd0);
    push(F_DISP, 16'hFFF, cyc + 2);
    push(F_DISP, 16'hFFF, cyc + 6);
    tick(8);

    c = cyc;
    bus.b1 = 1'b1; bus.b3 = 1'b1;
    push(F_MODE, 16'h0, c + 7);
    push(F_MODE, 16'h0, c + 8);
    tick(10);
    bus.b1 = 1'b0; bus.b3 = 1'b0;
    push(F_MODE, 16'h0, cyc + 8);
    tick(9);

    c = cyc;
    bus.b3 = 1'b1;
    push(F_MODE, 16'h0, c + 6);
    push(F_MODE, 16'h3, c + 7);
    for (int k = 50; k <= 1000; k += 50) push(F_MODE, 16'h3, c + k);
    tick(1000);
    bus.b3 = 1'b0;
    push(F_MODE, 16'h3, cyc + 9);
    tick(10);

    bus.a = 4'hF; bus.b = 4'h1; bus.sgn = 1'b0;
    bus.b1 = 1'b1;
    tick(4);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.disp !== 12'hFFF) begin
        errors++;
        $display("FAIL disp at async reset actual=%h required=fff", bus.disp);
    end
    checks++;
    if (bus.ledsbt !== 8'h00) begin
        errors++;
        $display("FAIL ledsbt at async reset actual=%h required=00", bus.ledsbt);
    end
    checks++;
    if (bus.flags !== 3'b000) begin
        errors++;
        $display("FAIL flags at async reset actual=%b required=000", bus.flags);
    end
    checks++;
    if (bus.mode !== 2'd0) begin
        errors++;
        $display("FAIL mode at async reset actual=%0d required=0", bus.mode);
    end
    push_reset_state(cyc);
    tick(1);
    push_reset_state(cyc);
    bus.b1 = 1'b0;
    tick(1);
    reset = 1'b1;
    rel = cyc;
    for (int k = 1; k <= 15; k++) push(F_MODE, 16'h0, cyc + k);
    push(F_FLAGS, 16'b001, cyc + 1);
    push(F_DISP, 16'hFFF, cyc + 2);
    push(F_DISP, 16'hFFF, cyc + 10);
    tick(17);

    foreach (sb[i]) begin
      errors++;
      $display("FAIL %s never compared, due cyc=%0d required=%h",
               fname(sb[i].fld), sb[i].cyc, sb[i].val);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
